mmcm_reconfig_ctrl: RTL and testbench

- Run-time reconfiguration controller for one MMCME2_ADV, driven through the MMCM's DRP port.
- On request it holds the MMCM in reset, then read-modify-writes a stored profile of DRP registers.
- It then releases reset and qualifies LOCKED before reporting a usable clock.
- Successor to the fixed-ratio clock generator: it selects among NUM_CFG frequency profiles without re-synthesis, and sits beside the MMCM/BUFG wrapper in the clocking top.

---
 rtl/mmcm_reconfig_pkg.sv | 56 +++++
 rtl/mmcm_cfg_rom.sv | 27 ++
 rtl/mmcm_reconfig_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mmcm_reconfig_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_reconfig_pkg.sv
// Shared types and the stored DRP profile table for the MMCM reconfiguration controller.
// Each entry is read-modify-written: mask bit 1 keeps the bit read back from the MMCM.
package mmcm_reconfig_pkg;

  localparam int TBL_CFG    = 4;
  localparam int TBL_REGS   = 8;
  localparam int TBL_CFG_AW = 2;
  localparam int TBL_REG_AW = 3;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } drp_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT_RST,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_WAIT,
    ST_RELEASE,
    ST_WAIT_LOCK
  } state_t;

  // Preserve-everything write to CLKOUT0 reg1, used for unpopulated slots.
  localparam drp_entry_t DRP_NOOP = '{addr: 7'h08, mask: 16'hFFFF, data: 16'h0000};

  // Row order per profile: CLKOUT0 reg1/reg2, CLKFBOUT reg1/reg2, DIVCLK, LOCK1, LOCK2, FILT.
  localparam drp_entry_t PROFILE_TBL [TBL_CFG][TBL_REGS] = '{
    '{ '{7'h08, 16'h1000, 16'h0104}, '{7'h09, 16'hFC00, 16'h0000},
       '{7'h14, 16'h1000, 16'h0145}, '{7'h15, 16'hFC00, 16'h0000},
       '{7'h16, 16'hC000, 16'h1041}, '{7'h18, 16'hFC00, 16'h00FA},
       '{7'h19, 16'h8000, 16'h7C01}, '{7'h4E, 16'h66FF, 16'h0800} },
    '{ '{7'h08, 16'h1000, 16'h0145}, '{7'h09, 16'hFC00, 16'h0000},
       '{7'h14, 16'h1000, 16'h0186}, '{7'h15, 16'hFC00, 16'h0000},
       '{7'h16, 16'hC000, 16'h1041}, '{7'h18, 16'hFC00, 16'h00FA},
       '{7'h19, 16'h8000, 16'h7C01}, '{7'h4E, 16'h66FF, 16'h0900} },
    '{ '{7'h08, 16'h1000, 16'h0186}, '{7'h09, 16'hFC00, 16'h0000},
       '{7'h14, 16'h1000, 16'h0145}, '{7'h15, 16'hFC00, 16'h0000},
       '{7'h16, 16'hC000, 16'h1041}, '{7'h18, 16'hFC00, 16'h00C8},
       '{7'h19, 16'h8000, 16'h7C01}, '{7'h4E, 16'h66FF, 16'h1100} },
    '{ '{7'h08, 16'h1000, 16'h028A}, '{7'h09, 16'hFC00, 16'h0000},
       '{7'h14, 16'h1000, 16'h01C7}, '{7'h15, 16'hFC00, 16'h0000},
       '{7'h16, 16'hC000, 16'h1041}, '{7'h18, 16'hFC00, 16'h0096},
       '{7'h19, 16'h8000, 16'h7C01}, '{7'h4E, 16'h66FF, 16'h9000} }
  };

  // Read-modify-write merge: mask bit 1 keeps the MMCM's current bit.
  function automatic logic [15:0] drp_merge(logic [15:0] rd, logic [15:0] mask,
                                            logic [15:0] data);
    return (rd & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/mmcm_cfg_rom.sv
// Combinational profile lookup: (profile, register index) -> DRP entry.
// Indices outside the stored table return a harmless preserve-all entry.
module mmcm_cfg_rom
  import mmcm_reconfig_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int IDX_W = 3
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [IDX_W-1:0] idx,
  output drp_entry_t       entry
);

  logic [TBL_CFG_AW-1:0] cfg_a;
  logic [TBL_REG_AW-1:0] reg_a;

  // Table read with range guard.
  always_comb begin
    cfg_a = TBL_CFG_AW'(sel);
    reg_a = TBL_REG_AW'(idx);
    entry = DRP_NOOP;
    if ((int'(sel) < TBL_CFG) && (int'(idx) < TBL_REGS)) begin
      entry = PROFILE_TBL[cfg_a][reg_a];
    end
  end

endmodule

// File: rtl/mmcm_reconfig_ctrl.sv
// Run-time MMCME2_ADV reconfiguration controller. Holds the MMCM in reset,
// read-modify-writes one stored profile over DRP, releases reset and
// qualifies LOCKED before reporting a usable clock.
module mmcm_reconfig_ctrl
  import mmcm_reconfig_pkg::*;
#(
  parameter int NUM_CFG      = 4,
  parameter int NUM_REGS     = 8,
  parameter int DRP_TIMEOUT  = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 256,
  parameter int SEL_W        = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_req,
  input  logic [SEL_W-1:0] i_cfg_sel,
  output logic             o_cfg_busy,
  output logic             o_cfg_done,
  output logic             o_cfg_err,
  output logic             o_locked,
  output logic [6:0]       o_daddr,
  output logic [15:0]      o_di,
  input  logic [15:0]      i_do,
  output logic             o_den,
  output logic             o_dwe,
  input  logic             i_drdy,
  output logic             o_mmcm_rst,
  input  logic             i_mmcm_locked
);

  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TMO_MAX = (DRP_TIMEOUT > LOCK_TIMEOUT) ? DRP_TIMEOUT : LOCK_TIMEOUT;
  localparam int TMO_W   = $clog2(TMO_MAX + 1);
  localparam int STB_W   = $clog2(LOCK_STABLE + 1);

  localparam logic [TMO_W-1:0] DRP_TMO_CNT  = TMO_W'(DRP_TIMEOUT);
  localparam logic [TMO_W-1:0] LOCK_TMO_CNT = TMO_W'(LOCK_TIMEOUT);
  localparam logic [STB_W-1:0] STB_CNT      = STB_W'(LOCK_STABLE);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_inc;
  logic [STB_W-1:0]   stb_q, stb_d, stb_inc;
  logic               mmcm_rst_q, mmcm_rst_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               qual_q, qual_d;
  logic               rd_cap;
  logic [15:0]        rd_q;
  logic               lock_s1, lock_s2;
  drp_entry_t         rom_entry;

  mmcm_cfg_rom #(
    .SEL_W (SEL_W),
    .IDX_W (IDX_W)
  ) u_rom (
    .sel   (sel_q),
    .idx   (idx_q),
    .entry (rom_entry)
  );

  // Two-flop synchroniser for the asynchronous LOCKED output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      lock_s1 <= i_mmcm_locked;
      lock_s2 <= lock_s1;
    end
  end

  // Control state; reset lands in RELEASE so the bitstream profile is relocked.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_RELEASE;
      sel_q      <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      stb_q      <= '0;
      mmcm_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      qual_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      stb_q      <= stb_d;
      mmcm_rst_q <= mmcm_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
      qual_q     <= qual_d;
    end
  end

  // Read-back capture; data only, so no reset.
  always_ff @(posedge i_clk) begin
    if (rd_cap) begin
      rd_q <= i_do;
    end
  end

  assign tmo_inc = tmo_q + TMO_W'(1);
  assign stb_inc = stb_q + STB_W'(1);

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    stb_d      = stb_q;
    mmcm_rst_d = mmcm_rst_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    qual_d     = qual_q;
    rd_cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cfg_req) begin
          if (int'(i_cfg_sel) < NUM_CFG) begin
            sel_d      = i_cfg_sel;
            idx_d      = '0;
            mmcm_rst_d = 1'b1;
            qual_d     = 1'b0;
            state_d    = ST_ASSERT_RST;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ASSERT_RST: state_d = ST_RD;
      ST_RD: begin
        tmo_d   = '0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (i_drdy) begin
          rd_cap  = 1'b1;
          state_d = ST_WR;
        end else if (tmo_inc == DRP_TMO_CNT) begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      ST_WR: begin
        tmo_d   = '0;
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (i_drdy) begin
          if (int'(idx_q) < NUM_REGS - 1) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_RD;
          end else begin
            state_d = ST_RELEASE;
          end
        end else if (tmo_inc == DRP_TMO_CNT) begin
          // Partially written profile is still relocked; software re-requests.
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      ST_RELEASE: begin
        mmcm_rst_d = 1'b0;
        tmo_d      = '0;
        stb_d      = '0;
        state_d    = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        stb_d = lock_s2 ? stb_inc : '0;
        tmo_d = tmo_inc;
        // Lock qualification takes priority over a coincident timeout.
        if (lock_s2 && (stb_inc == STB_CNT)) begin
          done_d  = 1'b1;
          qual_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_inc == LOCK_TMO_CNT) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RELEASE;
    endcase
  end

  // DRP strobes are Moore outputs of the single-cycle RD/WR states.
  always_comb begin
    o_den   = (state_q == ST_RD) || (state_q == ST_WR);
    o_dwe   = (state_q == ST_WR);
    o_daddr = o_den ? rom_entry.addr : 7'h00;
    o_di    = o_dwe ? drp_merge(rd_q, rom_entry.mask, rom_entry.data) : 16'h0000;
  end

  assign o_cfg_busy = (state_q != ST_IDLE);
  assign o_cfg_done = done_q;
  assign o_cfg_err  = err_q;
  assign o_mmcm_rst = mmcm_rst_q;
  assign o_locked   = (state_q == ST_IDLE) && qual_q && lock_s2;

endmodule

// File: tb/tb_mmcm_reconfig_ctrl.sv
// Directed bench for mmcm_reconfig_ctrl with a small DRP responder model.
module tb_mmcm_reconfig_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_req;
  logic [2:0]  cfg_sel;
  logic        cfg_busy, cfg_done, cfg_err, locked;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic [15:0] dout = 16'h0000;
  logic        den, dwe;
  logic        drdy = 1'b0;
  logic        mmcm_rst;
  logic        mmcm_locked;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // DRP responder state and log
  logic        drp_hold = 1'b0;
  int          drp_lat = 2;
  logic [15:0] rd_value = 16'hFFFF;
  int          pend = 0;
  logic        prev_den = 1'b0;
  int          den_overlap = 0, den_cnt = 0, rd_cnt = 0, wr_cnt = 0;
  logic [6:0]  rd_addr [8];
  logic [6:0]  wr_addr [8];
  logic [15:0] wr_data [8];

  mmcm_reconfig_ctrl #(
    .NUM_CFG(4), .NUM_REGS(2), .DRP_TIMEOUT(8), .LOCK_TIMEOUT(100),
    .LOCK_STABLE(4), .SEL_W(3)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_req(cfg_req), .i_cfg_sel(cfg_sel),
    .o_cfg_busy(cfg_busy), .o_cfg_done(cfg_done), .o_cfg_err(cfg_err),
    .o_locked(locked), .o_daddr(daddr), .o_di(di), .i_do(dout),
    .o_den(den), .o_dwe(dwe), .i_drdy(drdy), .o_mmcm_rst(mmcm_rst),
    .i_mmcm_locked(mmcm_locked)
  );

  always #5 clk = ~clk;

  // DRP responder: logs each access, answers after drp_lat edges unless held.
  always @(posedge clk) begin
    drdy <= 1'b0;
    if (den === 1'b1) begin
      if (prev_den) den_overlap++;
      if (dwe) begin
        if (wr_cnt < 8) begin wr_addr[wr_cnt] = daddr; wr_data[wr_cnt] = di; end
        wr_cnt++;
      end else begin
        if (rd_cnt < 8) rd_addr[rd_cnt] = daddr;
        rd_cnt++;
      end
      den_cnt++;
      pend = drp_hold ? 0 : drp_lat;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        drdy <= 1'b1;
        dout <= rd_value;
      end
    end
    prev_den = (den === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    do begin cyc(); n++; end while (cfg_done !== 1'b1 && n < lim);
  endtask

  task automatic wait_rst_low(input int lim);
    int n = 0;
    do begin cyc(); n++; end while (mmcm_rst !== 1'b0 && n < lim);
  endtask

  initial begin
    int n;
    int den_snap;
    logic seen;
    logic [6:0] pat;
    pat = 7'b1111011;
    rst_n = 1'b0; cfg_req = 1'b0; cfg_sel = 3'd0; mmcm_locked = 1'b0;

    // Reset values
    repeat (3) cyc();
    check("rst_mmcm_rst", 32'(mmcm_rst), 32'd1);
    check("rst_den", 32'(den), 32'd0);
    check("rst_dwe", 32'(dwe), 32'd0);
    check("rst_daddr", 32'(daddr), 32'd0);
    check("rst_di", 32'(di), 32'd0);
    check("rst_done", 32'(cfg_done), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_busy", 32'(cfg_busy), 32'd1);

    // Power-up relock of profile 0
    rst_n = 1'b1;
    cyc();
    check("pu_mmcm_rst_low", 32'(mmcm_rst), 32'd0);
    check("pu_busy", 32'(cfg_busy), 32'd1);
    repeat (9) cyc();
    mmcm_locked = 1'b1;
    wait_done(50, n);
    check("pu_done_seen", 32'(cfg_done), 32'd1);
    check("pu_done_latency", 32'(n), 32'd6);
    cyc();
    check("pu_done_one_cycle", 32'(cfg_done), 32'd0);
    check("pu_locked", 32'(locked), 32'd1);
    check("pu_busy_idle", 32'(cfg_busy), 32'd0);

    // Profile 1 reconfiguration with read-back 0xFFFF
    cfg_req = 1'b1; cfg_sel = 3'd1;
    cyc();
    cfg_req = 1'b0; mmcm_locked = 1'b0;
    check("p1_mmcm_rst", 32'(mmcm_rst), 32'd1);
    check("p1_locked_drop", 32'(locked), 32'd0);
    check("p1_busy", 32'(cfg_busy), 32'd1);
    wait_rst_low(60);
    check("p1_released", 32'(mmcm_rst), 32'd0);
    check("p1_rd_cnt", 32'(rd_cnt), 32'd2);
    check("p1_wr_cnt", 32'(wr_cnt), 32'd2);
    check("p1_rd0_addr", 32'(rd_addr[0]), 32'h08);
    check("p1_wr0_addr", 32'(wr_addr[0]), 32'h08);
    check("p1_wr0_data", 32'(wr_data[0]), 32'h1145);
    check("p1_rd1_addr", 32'(rd_addr[1]), 32'h09);
    check("p1_wr1_addr", 32'(wr_addr[1]), 32'h09);
    check("p1_wr1_data", 32'(wr_data[1]), 32'hFC00);
    mmcm_locked = 1'b1;
    wait_done(50, n);
    check("p1_done_seen", 32'(cfg_done), 32'd1);
    cyc();
    check("p1_locked", 32'(locked), 32'd1);

    // Out-of-range profile index
    den_snap = den_cnt;
    cfg_req = 1'b1; cfg_sel = 3'd5;
    cyc();
    cfg_req = 1'b0;
    check("bad_sel_err", 32'(cfg_err), 32'd1);
    check("bad_sel_busy", 32'(cfg_busy), 32'd0);
    cyc();
    check("bad_sel_err_pulse", 32'(cfg_err), 32'd0);
    check("bad_sel_busy2", 32'(cfg_busy), 32'd0);
    repeat (3) cyc();
    check("bad_sel_no_den", 32'(den_cnt - den_snap), 32'd0);

    // DRDY withheld during the first read
    drp_hold = 1'b1;
    den_snap = den_cnt;
    cfg_req = 1'b1; cfg_sel = 3'd2;
    cyc();
    cfg_req = 1'b0; mmcm_locked = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (den !== 1'b1 && n < 10);
    check("drp_to_den_seen", 32'(den), 32'd1);
    n = 0;
    do begin cyc(); n++; end while (cfg_err !== 1'b1 && n < 30);
    check("drp_to_err_seen", 32'(cfg_err), 32'd1);
    check("drp_to_latency", 32'(n), 32'd9);
    check("drp_to_still_rst", 32'(mmcm_rst), 32'd1);
    cyc();
    check("drp_to_err_pulse", 32'(cfg_err), 32'd0);
    check("drp_to_rst_low", 32'(mmcm_rst), 32'd0);
    check("drp_to_busy", 32'(cfg_busy), 32'd1);
    check("drp_to_one_den", 32'(den_cnt - den_snap), 32'd1);
    drp_hold = 1'b0;
    mmcm_locked = 1'b1;
    wait_done(50, n);
    check("drp_to_relock", 32'(cfg_done), 32'd1);

    // LOCKED glitch restarts stability count
    cfg_req = 1'b1; cfg_sel = 3'd3;
    cyc();
    cfg_req = 1'b0; mmcm_locked = 1'b0;
    wait_rst_low(60);
    check("glitch_released", 32'(mmcm_rst), 32'd0);
    seen = 1'b0; n = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      mmcm_locked = (i < 7) ? pat[i] : 1'b1;
      cyc();
      if (cfg_done === 1'b1) begin seen = 1'b1; n = i + 1; end
    end
    check("glitch_done_seen", 32'(seen), 32'd1);
    check("glitch_done_latency", 32'(n), 32'd9);

    // LOCKED never asserts
    cfg_req = 1'b1; cfg_sel = 3'd0;
    cyc();
    cfg_req = 1'b0; mmcm_locked = 1'b0;
    wait_rst_low(60);
    n = 0;
    do begin cyc(); n++; end while (cfg_err !== 1'b1 && n < 200);
    check("lock_to_err_seen", 32'(cfg_err), 32'd1);
    check("lock_to_latency", 32'(n), 32'd100);
    check("lock_to_no_done", 32'(cfg_done), 32'd0);
    check("lock_to_locked", 32'(locked), 32'd0);
    check("lock_to_idle", 32'(cfg_busy), 32'd0);

    // Async reset in WR_WAIT, then a request while busy
    cfg_req = 1'b1; cfg_sel = 3'd1;
    cyc();
    cfg_req = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (!(den === 1'b1 && dwe === 1'b1) && n < 20);
    check("ar_wr_seen", 32'(dwe), 32'd1);
    drp_hold = 1'b1;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check("ar_mmcm_rst", 32'(mmcm_rst), 32'd1);
    check("ar_den", 32'(den), 32'd0);
    check("ar_dwe", 32'(dwe), 32'd0);
    check("ar_daddr", 32'(daddr), 32'd0);
    check("ar_di", 32'(di), 32'd0);
    check("ar_done", 32'(cfg_done), 32'd0);
    check("ar_err", 32'(cfg_err), 32'd0);
    check("ar_locked", 32'(locked), 32'd0);
    check("ar_busy", 32'(cfg_busy), 32'd1);
    cyc();
    cyc();
    check("ar_hold_rst", 32'(mmcm_rst), 32'd1);
    rst_n = 1'b1;
    drp_hold = 1'b0;
    den_snap = den_cnt;
    cyc();
    check("ar_release", 32'(mmcm_rst), 32'd0);
    cfg_req = 1'b1; cfg_sel = 3'd2;
    cyc();
    cfg_req = 1'b0;
    mmcm_locked = 1'b1;
    wait_done(50, n);
    check("ar_done_seen", 32'(cfg_done), 32'd1);
    repeat (3) cyc();
    check("ar_req_ignored_busy", 32'(cfg_busy), 32'd0);
    check("ar_req_ignored_den", 32'(den_cnt - den_snap), 32'd0);
    check("ar_locked_final", 32'(locked), 32'd1);

    // Lock loss in IDLE
    mmcm_locked = 1'b0;
    cyc();
    cyc();
    check("idle_lock_loss", 32'(locked), 32'd0);

    check("den_never_back_to_back", 32'(den_overlap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
